// File: rtl/spi_ram_burst_wrapper.sv
// SPI-slave front end to a single-port register RAM: 2-bit command, then address or
// data words shifted MSB first, with optional auto-increment bursts and abort detection.
module spi_ram_burst_wrapper #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int AUTO_INC = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic ss_n,
  input  logic mosi,
  output logic miso,
  output logic busy,
  output logic abort
);

  localparam int MEM_DEPTH = 2 ** ADDR_W;
  localparam int MAX_W     = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W     = $clog2(MAX_W + 1);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    SH_ADDR,
    SH_WDATA,
    RD_LOAD,
    SH_RDATA,
    DONE
  } state_t;

  state_t state, next_state;

  logic              cmd_hi;
  logic              addr_is_rd;
  logic [MAX_W-1:0]  shreg;
  logic [MAX_W-1:0]  in_word;
  logic [DATA_W-1:0] rdbuf;
  logic [CNT_W-1:0]  bit_cnt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [DATA_W-1:0] mem [MEM_DEPTH];

  logic abort_nxt;
  logic cap_hi;
  logic cap_cmd;
  logic shift_in;
  logic addr_last;
  logic wdata_last;
  logic rd_load;
  logic rd_shift;

  assign in_word = {shreg[MAX_W-2:0], mosi};
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Any ss_n=1 edge outside IDLE ends the frame; abort only if a word or command was cut short.
  always_comb begin
    next_state = state;
    abort_nxt  = 1'b0;
    cap_hi     = 1'b0;
    cap_cmd    = 1'b0;
    shift_in   = 1'b0;
    addr_last  = 1'b0;
    wdata_last = 1'b0;
    rd_load    = 1'b0;
    rd_shift   = 1'b0;
    case (state)
      IDLE: begin
        if (!ss_n) begin
          cap_hi     = 1'b1;
          next_state = CMD;
        end
      end
      CMD: begin
        if (ss_n) begin
          next_state = IDLE;
          abort_nxt  = 1'b1;
        end else begin
          cap_cmd = 1'b1;
          case ({cmd_hi, mosi})
            2'b00, 2'b10: next_state = SH_ADDR;
            2'b01:        next_state = SH_WDATA;
            default:      next_state = RD_LOAD;
          endcase
        end
      end
      SH_ADDR: begin
        if (ss_n) begin
          next_state = IDLE;
          abort_nxt  = (bit_cnt != '0);
        end else if (bit_cnt == CNT_W'(ADDR_W - 1)) begin
          addr_last  = 1'b1;
          next_state = DONE;
        end else begin
          shift_in = 1'b1;
        end
      end
      SH_WDATA: begin
        if (ss_n) begin
          next_state = IDLE;
          abort_nxt  = (bit_cnt != '0);
        end else if (bit_cnt == CNT_W'(DATA_W - 1)) begin
          wdata_last = 1'b1;
          if (AUTO_INC == 0) next_state = DONE;
        end else begin
          shift_in = 1'b1;
        end
      end
      RD_LOAD: begin
        if (ss_n) begin
          next_state = IDLE;
        end else begin
          rd_load    = 1'b1;
          next_state = SH_RDATA;
        end
      end
      SH_RDATA: begin
        if (ss_n) begin
          next_state = IDLE;
          abort_nxt  = (bit_cnt != '0);
        end else if (bit_cnt != '0) begin
          rd_shift = 1'b1;
        end else if (AUTO_INC != 0) begin
          rd_load = 1'b1;
        end else begin
          next_state = DONE;
        end
      end
      DONE: begin
        if (ss_n) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // In SH_RDATA the counter wraps to 0 once the last bit of a word is on miso,
  // so a zero count there marks a clean word boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      miso       <= 1'b0;
      abort      <= 1'b0;
      cmd_hi     <= 1'b0;
      addr_is_rd <= 1'b0;
      shreg      <= '0;
      rdbuf      <= '0;
      bit_cnt    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      abort <= abort_nxt;
      miso  <= 1'b0;
      if (cap_hi) cmd_hi <= mosi;
      if (cap_cmd) begin
        addr_is_rd <= cmd_hi;
        bit_cnt    <= '0;
        shreg      <= '0;
      end
      if (shift_in) begin
        shreg   <= in_word;
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (addr_last) begin
        if (addr_is_rd) rd_ptr <= in_word[ADDR_W-1:0];
        else            wr_ptr <= in_word[ADDR_W-1:0];
        bit_cnt <= '0;
        shreg   <= '0;
      end
      if (wdata_last) begin
        if (AUTO_INC != 0) wr_ptr <= wr_ptr + 1'b1;
        bit_cnt <= '0;
        shreg   <= '0;
      end
      if (rd_load) begin
        rdbuf   <= mem[rd_ptr];
        miso    <= mem[rd_ptr][DATA_W-1];
        bit_cnt <= CNT_W'(1);
        if (AUTO_INC != 0) rd_ptr <= rd_ptr + 1'b1;
      end
      if (rd_shift) begin
        miso    <= rdbuf[DATA_W-2];
        rdbuf   <= {rdbuf[DATA_W-2:0], 1'b0};
        bit_cnt <= (bit_cnt == CNT_W'(DATA_W - 1)) ? '0 : bit_cnt + 1'b1;
      end
      if (next_state == IDLE) begin
        bit_cnt <= '0;
        shreg   <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wdata_last) mem[wr_ptr] <= in_word[DATA_W-1:0];
  end

endmodule

// File: tb/tb_spi_ram_burst_wrapper.sv
// Directed bench for spi_ram_burst_wrapper: three instances cover AUTO_INC=0, AUTO_INC=1
// and a 4-bit address / 16-bit data configuration; read words are checked against a queue.
module tb_spi_ram_burst_wrapper;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] ss_n;
  logic [2:0] mosi;
  logic [2:0] miso;
  logic [2:0] busy;
  logic [2:0] abort;

  int n_compared   = 0;
  int n_mismatched = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  spi_ram_burst_wrapper #(.ADDR_W(8), .DATA_W(8), .AUTO_INC(0)) u_single (
    .clk(clk), .rst(rst), .ss_n(ss_n[0]), .mosi(mosi[0]),
    .miso(miso[0]), .busy(busy[0]), .abort(abort[0])
  );

  spi_ram_burst_wrapper #(.ADDR_W(8), .DATA_W(8), .AUTO_INC(1)) u_burst (
    .clk(clk), .rst(rst), .ss_n(ss_n[1]), .mosi(mosi[1]),
    .miso(miso[1]), .busy(busy[1]), .abort(abort[1])
  );

  spi_ram_burst_wrapper #(.ADDR_W(4), .DATA_W(16), .AUTO_INC(1)) u_wide (
    .clk(clk), .rst(rst), .ss_n(ss_n[2]), .mosi(mosi[2]),
    .miso(miso[2]), .busy(busy[2]), .abort(abort[2])
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one serial bit before the next rising edge, then settle just past it.
  task automatic drive(input int sel, input logic s, input logic d);
    @(negedge clk);
    ss_n[sel] = s;
    mosi[sel] = d;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int sel, input logic [1:0] cmd, input logic [63:0] payload,
                               input int nbits, input logic exp_abort, input string tag);
    drive(sel, 1'b0, cmd[1]);
    drive(sel, 1'b0, cmd[0]);
    for (int i = nbits - 1; i >= 0; i--) drive(sel, 1'b0, payload[i]);
    drive(sel, 1'b1, 1'b0);
    checkOutput({tag, "_abort"}, 32'(abort[sel]), 32'(exp_abort));
    checkOutput({tag, "_busy"}, 32'(busy[sel]), 32'd0);
  endtask

  task automatic readWords(input int sel, input int dw, input int nwords, input int tail,
                           input string tag);
    logic [31:0] word;
    logic [31:0] exp;
    drive(sel, 1'b0, 1'b1);
    drive(sel, 1'b0, 1'b1);
    for (int w = 0; w < nwords; w++) begin
      word = '0;
      for (int b = 0; b < dw; b++) begin
        drive(sel, 1'b0, 1'b0);
        word = {word[30:0], miso[sel]};
      end
      if (sb.size() == 0) begin
        checkOutput({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
        exp = sb.pop_front();
        checkOutput({tag, "_word"}, word, exp);
      end
    end
    for (int t = 0; t < tail; t++) begin
      drive(sel, 1'b0, 1'b1);
      checkOutput({tag, "_tail_miso"}, 32'(miso[sel]), 32'd0);
    end
    drive(sel, 1'b1, 1'b0);
    checkOutput({tag, "_end_abort"}, 32'(abort[sel]), 32'd0);
    checkOutput({tag, "_end_busy"}, 32'(busy[sel]), 32'd0);
  endtask

  initial begin
    rst  = 1'b1;
    ss_n = 3'b111;
    mosi = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      checkOutput("rst_miso", 32'(miso[s]), 32'd0);
      checkOutput("rst_busy", 32'(busy[s]), 32'd0);
      checkOutput("rst_abort", 32'(abort[s]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of a WR_ADDR frame; rd_ptr must return to 0.
    applyStimulus(0, 2'b01, 64'h5A, 8, 1'b0, "t1_wr0");
    applyStimulus(0, 2'b10, 64'h77, 8, 1'b0, "t1_rdaddr");
    drive(0, 1'b0, 1'b0);
    drive(0, 1'b0, 1'b0);
    drive(0, 1'b0, 1'b1);
    drive(0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("t1_mid_rst_miso", 32'(miso[0]), 32'd0);
    checkOutput("t1_mid_rst_busy", 32'(busy[0]), 32'd0);
    checkOutput("t1_mid_rst_abort", 32'(abort[0]), 32'd0);
    @(negedge clk);
    rst     = 1'b0;
    ss_n[0] = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t1_post_rst_abort", 32'(abort[0]), 32'd0);
    sb.push_back(32'h5A);
    readWords(0, 8, 1, 1, "t1_rd_addr0");

    // Single-word access with AUTO_INC=0.
    applyStimulus(0, 2'b00, 64'h3C, 8, 1'b0, "t2_wraddr");
    applyStimulus(0, 2'b01, 64'hA5, 8, 1'b0, "t2_wrdata");
    applyStimulus(0, 2'b10, 64'h3C, 8, 1'b0, "t2_rdaddr");
    sb.push_back(32'hA5);
    readWords(0, 8, 1, 1, "t2_rd");
    applyStimulus(0, 2'b01, {53'd0, 8'hC3, 3'b101}, 11, 1'b0, "t2_done_extra");

    // WR_DATA cut after 5 of 8 bits.
    drive(0, 1'b0, 1'b0);
    drive(0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) drive(0, 1'b0, 1'b1);
    drive(0, 1'b1, 1'b0);
    checkOutput("t4_abort_pulse", 32'(abort[0]), 32'd1);
    checkOutput("t4_busy", 32'(busy[0]), 32'd0);
    drive(0, 1'b1, 1'b0);
    checkOutput("t4_abort_clear", 32'(abort[0]), 32'd0);
    sb.push_back(32'hC3);
    readWords(0, 8, 1, 1, "t4_unchanged");

    // Burst write across the pointer wrap, then gapless burst read.
    applyStimulus(1, 2'b00, 64'hFE, 8, 1'b0, "t3_wraddr");
    applyStimulus(1, 2'b01, 64'h112233, 24, 1'b0, "t3_burst_wr");
    applyStimulus(1, 2'b10, 64'hFE, 8, 1'b0, "t3_rdaddr");
    sb.push_back(32'h11);
    sb.push_back(32'h22);
    sb.push_back(32'h33);
    readWords(1, 8, 3, 0, "t3_burst_rd");
    applyStimulus(1, 2'b10, 64'h00, 8, 1'b0, "t3_rdaddr0");
    sb.push_back(32'h33);
    readWords(1, 8, 1, 0, "t3_wrap_rd");

    // Frame ended after one command bit, and a read ended mid-word.
    drive(1, 1'b0, 1'b0);
    drive(1, 1'b1, 1'b0);
    checkOutput("t5_cmd_abort", 32'(abort[1]), 32'd1);
    checkOutput("t5_cmd_busy", 32'(busy[1]), 32'd0);
    drive(1, 1'b0, 1'b1);
    drive(1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) drive(1, 1'b0, 1'b0);
    drive(1, 1'b1, 1'b0);
    checkOutput("t5_rd_abort", 32'(abort[1]), 32'd1);

    // 4-bit address, 16-bit data burst with wrap.
    applyStimulus(2, 2'b00, 64'hF, 4, 1'b0, "t6_wraddr");
    applyStimulus(2, 2'b01, 64'hBEEF_1234, 32, 1'b0, "t6_burst_wr");
    applyStimulus(2, 2'b10, 64'hF, 4, 1'b0, "t6_rdaddr");
    sb.push_back(32'hBEEF);
    sb.push_back(32'h1234);
    readWords(2, 16, 2, 0, "t6_rd");

    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
